// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop,
// consuming one operand bit per clock, LSB first. Subtraction is performed
// as a + ~b + 1 by inverting B and forcing the initial carry on accept.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic [WIDTH-1:0] sreg;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bit_s;
    logic             bit_c;
    logic             accept;
    logic             last;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    // Full-adder cell on the current low bits, plus handshake decode
    always_comb begin
        bit_s  = fa_sum(areg[0], breg[0], carry);
        bit_c  = fa_carry(areg[0], breg[0], carry);
        accept = (state == IDLE) && start;
        last   = (state == RUN) && (cnt == LAST_BIT);
    end

    assign busy = (state == RUN);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: run for exactly WIDTH bit steps after accept
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST_BIT) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, bit-serial shift and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            areg  <= '0;
            breg  <= '0;
            sreg  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                areg  <= a;
                breg  <= sub ? ~b : b;
                carry <= sub ? 1'b1 : cin;
                cnt   <= '0;
            end else if (state == RUN) begin
                areg  <= areg >> 1;
                breg  <= breg >> 1;
                sreg  <= {bit_s, sreg[WIDTH-1:1]};
                carry <= bit_c;
                if (last) begin
                    // Counter parks at zero so it never wraps mid-operation.
                    cnt  <= '0;
                    sum  <= {bit_s, sreg[WIDTH-1:1]};
                    cout <= bit_c;
                    // Signed overflow: carry into the MSB differs from carry out.
                    ovf  <= carry ^ bit_c;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule
